// File: rtl/washer_phase_timer_if.sv
// washer_phase_timer_if: signal bundle between the washer FSM and its phase timer.
//   master : FSM side. Drives the actuator outputs and hold, receives the T flags.
//   slave  : timer side. Receives the actuator outputs and hold, drives the T flags,
//            the latched phase and the remaining tick count.
// Signal names follow the washer FSM so the two blocks can be wired by name.
interface washer_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             Water;
  logic             Agitator;
  logic             R;
  logic             Pump;
  logic             Motor;
  logic             hold;
  logic             Tf;
  logic             Tw;
  logic             Tr;
  logic             Td;
  logic             Ts;
  logic [2:0]       phase;
  logic [CNT_W-1:0] remaining;

  modport master (
    output Water, Agitator, R, Pump, Motor, hold,
    input  Tf, Tw, Tr, Td, Ts, phase, remaining
  );

  modport slave (
    input  Water, Agitator, R, Pump, Motor, hold,
    output Tf, Tw, Tr, Td, Ts, phase, remaining
  );
endinterface

// File: rtl/washer_phase_timer.sv
// washer_phase_timer: decodes the washer cycle phase from the FSM actuator outputs
// and runs a prescaled down-counter for it. When the phase's duration has elapsed
// the matching T flag (Tf/Tw/Tr/Td/Ts) is raised as a level until the phase changes.
// Ports:
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : slave side of washer_phase_timer_if (actuators + hold in; T flags,
//           phase and remaining out)
// Durations are in ticks of PRESCALE clk cycles and are truncated to CNT_W bits.
module washer_phase_timer #(
  parameter int PRESCALE = 1000,
  parameter int CNT_W    = 8,
  parameter int FILL_T   = 20,
  parameter int WASH_T   = 40,
  parameter int RINSE_T  = 30,
  parameter int DRAIN_T  = 15,
  parameter int SPIN_T   = 50
) (
  input  logic                 clk,
  input  logic                 reset,
  washer_phase_timer_if.slave  bus
);

  localparam logic [2:0] PH_NONE  = 3'd0;
  localparam logic [2:0] PH_FILL  = 3'd1;
  localparam logic [2:0] PH_WASH  = 3'd2;
  localparam logic [2:0] PH_RINSE = 3'd3;
  localparam logic [2:0] PH_DRAIN = 3'd4;
  localparam logic [2:0] PH_SPIN  = 3'd5;

  // PRESCALE=1 still needs a 1-bit prescaler; it simply ticks every cycle.
  localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  localparam logic [CNT_W-1:0] FILL_N  = CNT_W'(FILL_T);
  localparam logic [CNT_W-1:0] WASH_N  = CNT_W'(WASH_T);
  localparam logic [CNT_W-1:0] RINSE_N = CNT_W'(RINSE_T);
  localparam logic [CNT_W-1:0] DRAIN_N = CNT_W'(DRAIN_T);
  localparam logic [CNT_W-1:0] SPIN_N  = CNT_W'(SPIN_T);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       phase_q, phase_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [PW-1:0]    pre_q, pre_d;
  logic [2:0]       dec_phase;
  logic [CNT_W-1:0] dec_dur;

  // Phase decode: water outranks agitation, spin outranks drain because the
  // pump also runs during spin.
  always_comb begin
    if (bus.Water)         dec_phase = PH_FILL;
    else if (bus.Agitator) dec_phase = bus.R ? PH_RINSE : PH_WASH;
    else if (bus.Motor)    dec_phase = PH_SPIN;
    else if (bus.Pump)     dec_phase = PH_DRAIN;
    else                   dec_phase = PH_NONE;
  end

  always_comb begin
    unique case (dec_phase)
      PH_FILL:  dec_dur = FILL_N;
      PH_WASH:  dec_dur = WASH_N;
      PH_RINSE: dec_dur = RINSE_N;
      PH_DRAIN: dec_dur = DRAIN_N;
      PH_SPIN:  dec_dur = SPIN_N;
      default:  dec_dur = '0;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      phase_q <= PH_NONE;
      rem_q   <= '0;
      pre_q   <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      rem_q   <= rem_d;
      pre_q   <= pre_d;
    end
  end

  // Next state. A phase change beats everything, including a tick that would
  // have finished the old phase on the same edge.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    rem_d   = rem_q;
    pre_d   = pre_q;
    if (dec_phase != phase_q) begin
      phase_d = dec_phase;
      rem_d   = dec_dur;
      pre_d   = '0;
      state_d = (dec_phase == PH_NONE) ? IDLE : RUN;
    end else begin
      unique case (state_q)
        IDLE: begin
          rem_d = '0;
          pre_d = '0;
        end
        RUN: begin
          if (!bus.hold) begin
            if (rem_q == '0) begin
              // Zero-length phase: finish on the first unheld edge.
              state_d = DONE;
            end else if (pre_q == PRE_LAST) begin
              pre_d = '0;
              rem_d = rem_q - 1'b1;
              if (rem_q == CNT_W'(1)) state_d = DONE;
            end else begin
              pre_d = pre_q + 1'b1;
            end
          end
        end
        DONE: ;
        default: state_d = IDLE;
      endcase
    end
  end

  // Outputs come straight from registers; the T flag is just DONE qualified
  // by the latched phase, so at most one can be high.
  always_comb begin
    bus.Tf        = (state_q == DONE) && (phase_q == PH_FILL);
    bus.Tw        = (state_q == DONE) && (phase_q == PH_WASH);
    bus.Tr        = (state_q == DONE) && (phase_q == PH_RINSE);
    bus.Td        = (state_q == DONE) && (phase_q == PH_DRAIN);
    bus.Ts        = (state_q == DONE) && (phase_q == PH_SPIN);
    bus.phase     = phase_q;
    bus.remaining = rem_q;
  end

endmodule
